// File: rtl/cdc_pkg.sv
// Shared helpers for the dual-clock FIFO: Gray/binary conversion and
// synchroniser depth limits.
package cdc_pkg;

   localparam int CDC_SYNC_STAGES_MIN = 2;
   localparam int CDC_SYNC_STAGES_MAX = 4;
   localparam int CDC_PTR_MAX_W       = 32;

   typedef logic [CDC_PTR_MAX_W-1:0] cdc_ptr_t;

   // Callers zero-extend narrower pointers; leading zeros leave the low bits
   // of either conversion unchanged, so truncating the result is exact.
   function automatic cdc_ptr_t bin2gray(input cdc_ptr_t b);
      return b ^ (b >> 1);
   endfunction

   function automatic cdc_ptr_t gray2bin(input cdc_ptr_t g);
      cdc_ptr_t b;
      b[CDC_PTR_MAX_W-1] = g[CDC_PTR_MAX_W-1];
      for (int i = CDC_PTR_MAX_W-2; i >= 0; i--)
         b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

endpackage

// File: rtl/cdc_sync_bus.sv
// Multi-flop synchroniser chain with asynchronous clear; used for Gray
// pointers and, at width 1, for per-domain reset release.
module cdc_sync_bus
   import cdc_pkg::*;
#(
   parameter int WIDTH  = 1,
   parameter int STAGES = CDC_SYNC_STAGES_MIN
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] chain [STAGES];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < STAGES; i++)
            chain[i] <= '0;
      end else begin
         chain[0] <= d;
         for (int i = 1; i < STAGES; i++)
            chain[i] <= chain[i-1];
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/cdc_async_fifo.sv
// Dual-clock FIFO, clk (write) to clk_rd (read), Gray pointers crossing via
// cdc_sync_bus. Define CDC_FIFO_ERR_FLAGS_EN for sticky overflow/underflow.
module cdc_async_fifo
   import cdc_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int ADDR_W      = 3,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clk_rd,
   input  logic              wr_en,
   input  logic [WIDTH-1:0]  wr_data,
   output logic              full,
   output logic [ADDR_W:0]   wr_level,
   input  logic              rd_en,
   output logic [WIDTH-1:0]  rd_data,
   output logic              rd_valid,
   output logic              empty,
   output logic [ADDR_W:0]   rd_level
`ifdef CDC_FIFO_ERR_FLAGS_EN
   ,
   output logic              overflow,
   output logic              underflow
`endif
);

   localparam int PW    = ADDR_W + 1;
   localparam int DEPTH = 1 << ADDR_W;

   typedef logic [PW-1:0] ptr_t;

   if (SYNC_STAGES < CDC_SYNC_STAGES_MIN || SYNC_STAGES > CDC_SYNC_STAGES_MAX) begin : g_bad_sync_stages
      $error("cdc_async_fifo: SYNC_STAGES must be in 2..4");
   end

   logic [WIDTH-1:0] mem [DEPTH];

   logic wrst_n;
   logic rrst_n;

   // Assertion clears the chain at once; release ripples through per domain.
   cdc_sync_bus #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_wrst_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (1'b1),
      .q     (wrst_n)
   );

   cdc_sync_bus #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_rrst_sync (
      .clk   (clk_rd),
      .rst_n (rst_n),
      .d     (1'b1),
      .q     (rrst_n)
   );

   ptr_t wbin, wgray, wbin_next, wgray_next;
   ptr_t rbin, rgray, rbin_next, rgray_next;
   ptr_t rgray_sync, wgray_sync, full_gray;
   logic wr_ok, rd_ok;

   cdc_sync_bus #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_rptr_sync (
      .clk   (clk),
      .rst_n (wrst_n),
      .d     (rgray),
      .q     (rgray_sync)
   );

   cdc_sync_bus #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_wptr_sync (
      .clk   (clk_rd),
      .rst_n (rrst_n),
      .d     (wgray),
      .q     (wgray_sync)
   );

   // Write domain
   assign wr_ok      = wr_en && !full;
   assign wbin_next  = wbin + ptr_t'(wr_ok);
   assign wgray_next = ptr_t'(bin2gray(cdc_ptr_t'(wbin_next)));
   // Full when the writer is exactly one lap ahead: top two Gray bits inverted.
   assign full_gray  = rgray_sync ^ (ptr_t'(3) << (ADDR_W - 1));

   always_ff @(posedge clk or negedge wrst_n) begin
      if (!wrst_n) begin
         wbin  <= '0;
         wgray <= '0;
         full  <= 1'b0;
      end else begin
         wbin  <= wbin_next;
         wgray <= wgray_next;
         full  <= (wgray_next == full_gray);
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok)
         mem[wbin[ADDR_W-1:0]] <= wr_data;
   end

   assign wr_level = wbin - ptr_t'(gray2bin(cdc_ptr_t'(rgray_sync)));

   // Read domain
   assign rd_ok      = rd_en && !empty;
   assign rbin_next  = rbin + ptr_t'(rd_ok);
   assign rgray_next = ptr_t'(bin2gray(cdc_ptr_t'(rbin_next)));

   always_ff @(posedge clk_rd or negedge rrst_n) begin
      if (!rrst_n) begin
         rbin     <= '0;
         rgray    <= '0;
         empty    <= 1'b1;
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         rbin     <= rbin_next;
         rgray    <= rgray_next;
         empty    <= (rgray_next == wgray_sync);
         rd_valid <= rd_ok;
         if (rd_ok)
            rd_data <= mem[rbin[ADDR_W-1:0]];
      end
   end

   assign rd_level = ptr_t'(gray2bin(cdc_ptr_t'(wgray_sync))) - rbin;

`ifdef CDC_FIFO_ERR_FLAGS_EN
   always_ff @(posedge clk or negedge wrst_n) begin
      if (!wrst_n)
         overflow <= 1'b0;
      else if (wr_en && full)
         overflow <= 1'b1;
   end

   always_ff @(posedge clk_rd or negedge rrst_n) begin
      if (!rrst_n)
         underflow <= 1'b0;
      else if (rd_en && empty)
         underflow <= 1'b1;
   end
`endif

endmodule
